// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants and helpers for the 7-segment scan controller.
//   SEG_BLANK : segment bus value with every segment and the DP dark
//   AN_OFF    : anode bus value with every digit undriven (sliced to N_DIGITS)
//   width_for : counter width for a modulus, never narrower than 1 bit
//               (used for the prescaler width PRESC_W and index width IDX_W)
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [7:0]            SEG_BLANK = 8'hFF;
  localparam logic [MAX_DIGITS-1:0] AN_OFF    = '1;

  // Board segment pins below bit 7, active-low.
  typedef logic [6:0] seg_pins_t;

  function automatic int width_for(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
//   Hex nibble to 7-segment decoder for the board's segment wiring.
//   hex_i [3:0] : nibble 0..F
//   seg_o [6:0] : active-low segment pins in board order {a, f, b, g, e, c, d}
//                 (bit 6 = a ... bit 0 = d); a lowercase b/d is used for 0xB/0xD
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_pins_t  seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'h08;
      4'h1: seg_o = 7'h6D;
      4'h2: seg_o = 7'h22;
      4'h3: seg_o = 7'h24;
      4'h4: seg_o = 7'h45;
      4'h5: seg_o = 7'h14;
      4'h6: seg_o = 7'h10;
      4'h7: seg_o = 7'h2D;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h04;
      4'hA: seg_o = 7'h01;
      4'hB: seg_o = 7'h50;
      4'hC: seg_o = 7'h1A;
      4'hD: seg_o = 7'h60;
      4'hE: seg_o = 7'h12;
      4'hF: seg_o = 7'h13;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for an N-digit common-anode display.
//   Holds an active frame (digits, DP, enables) plus one pending frame that
//   is committed only when the scan wraps, so a frame is never torn.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   load_i    : strobe, captures data_i/dp_i/en_i
//   data_i    : hex digits, digit k at [4k+3:4k], digit 0 rightmost
//   dp_i      : decimal point per digit, 1 = lit
//   en_i      : digit enable, 0 = anode never driven
//   pending_o : a loaded frame is waiting for the next wrap
//   frame_o   : one-cycle pulse after the scan wraps digit N-1 -> 0
//   an_o      : active-low anodes, one-hot-low or all-high
//   seg_o     : active-low {dp, segment pins}
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   en_i,
  output logic                  pending_o,
  output logic                  frame_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [7:0]            seg_o
);

  localparam int PRESC_W = width_for(REFRESH_DIV);
  localparam int IDX_W   = width_for(N_DIGITS);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                  pending_q, pending_d;
  logic                  frame_q;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic                  tick, boundary;
  logic [3:0]            cur_digit;
  seg_pins_t             dec_seg;
  logic [N_DIGITS-1:0]   blank_mask;
  logic                  lz_seen;

  assign tick     = (presc_q == PRESC_W'(REFRESH_DIV - 1));
  assign boundary = tick && (idx_q == IDX_W'(N_DIGITS - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // A load on the wrap cycle goes straight to the active frame and drops any
  // older pending frame; otherwise loads park in the pending frame.
  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pending_d   = pending_q;
    if (load_i && boundary) begin
      act_data_d = data_i;
      act_dp_d   = dp_i;
      act_en_d   = en_i;
      pending_d  = 1'b0;
    end else if (load_i) begin
      pend_data_d = data_i;
      pend_dp_d   = dp_i;
      pend_en_d   = en_i;
      pending_d   = 1'b1;
    end else if (boundary && pending_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      act_en_d   = pend_en_q;
      pending_d  = 1'b0;
    end
  end

  // Walk from the top digit down; a digit is blanked while no enabled
  // non-zero digit has been seen at or above it. Digit 0 always shows.
  always_comb begin
    lz_seen    = 1'b0;
    blank_mask = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lz_seen       = lz_seen | (act_en_q[k] && (act_data_q[4*k +: 4] != 4'h0));
      blank_mask[k] = BLANK_LZ && (k != 0) && !lz_seen;
    end
  end

  assign cur_digit = act_data_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF[N_DIGITS-1:0];
    seg_d = SEG_BLANK;
    if (act_en_q[idx_q]) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = {~act_dp_q[idx_q], blank_mask[idx_q] ? 7'h7F : dec_seg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pending_q   <= 1'b0;
      frame_q     <= 1'b0;
      an_q        <= AN_OFF[N_DIGITS-1:0];
      seg_q       <= SEG_BLANK;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pending_q   <= pending_d;
      frame_q     <= boundary;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign pending_o = pending_q;
  assign frame_o   = frame_q;
  assign an_o      = an_q;
  assign seg_o     = seg_q;

endmodule
